// File: rtl/vm1_qbus_slave.sv
// Qbus/MPI target for the vm1 initiator: latches the address on SYNC, decodes a
// word-aligned window and answers DATI/DATO(B)/DATIO from an internal word RAM.
module vm1_qbus_slave #(
  parameter logic [15:0] BASE_ADDR = 16'o100000,
  parameter int unsigned AW        = 6,
  parameter int unsigned WAIT      = 0
) (
  input  logic        pin_clk,
  input  logic        pin_init,
  input  logic [15:0] pin_ad_in,
  output logic [15:0] pin_ad_out,
  output logic        pin_ad_ena,
  input  logic        pin_sync_in,
  input  logic        pin_din_in,
  input  logic        pin_dout_in,
  input  logic        pin_wtbt_in,
  output logic        pin_rply_out,
  output logic        pin_sel
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_MISS = 3'd2,
    ST_WAIT = 3'd3,
    ST_RD   = 3'd4,
    ST_WR   = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT);

  state_t      state_q,  state_d;
  logic        sync_q,   sync_d;
  logic [AW:0] adr_q,    adr_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic        is_rd_q,  is_rd_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic        ad_ena_q, ad_ena_d;
  logic        rply_q,   rply_d;
  logic        sel_q,    sel_d;

  logic [15:0] mem [2**AW];
  logic [15:0] mem_rdata;
  logic [15:0] wr_word;
  logic        mem_we;
  logic        hit;
  logic        strobe;

  assign mem_rdata = mem[adr_q[AW:1]];
  assign hit       = (pin_ad_in[15:AW+1] == BASE_ADDR[15:AW+1]);
  // the strobe that opened the current data phase decides when it ends
  assign strobe    = is_rd_q ? pin_din_in : pin_dout_in;

  always_comb begin
    wr_word = mem_rdata;
    if (!pin_wtbt_in) begin
      wr_word = pin_ad_in;
    end else if (adr_q[0]) begin
      wr_word[15:8] = pin_ad_in[15:8];
    end else begin
      wr_word[7:0] = pin_ad_in[7:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = pin_sync_in;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    is_rd_d  = is_rd_q;
    ad_out_d = ad_out_q;
    ad_ena_d = ad_ena_q;
    rply_d   = rply_q;
    sel_d    = sel_q;
    mem_we   = 1'b0;

    if (!pin_sync_in) begin
      // end of bus cycle overrides everything, including a pending write
      state_d  = ST_IDLE;
      cnt_d    = '0;
      ad_out_d = '0;
      ad_ena_d = 1'b0;
      rply_d   = 1'b0;
      sel_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!sync_q) begin
            adr_d = pin_ad_in[AW:0];
            if (hit) begin
              state_d = ST_ADDR;
              sel_d   = 1'b1;
            end else begin
              state_d = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          state_d = ST_MISS;
        end
        ST_ADDR: begin
          if (pin_din_in && pin_dout_in) begin
            state_d = ST_MISS;
            sel_d   = 1'b0;
          end else if (pin_din_in || pin_dout_in) begin
            is_rd_d = pin_din_in;
            if (WAIT == 0) begin
              state_d = pin_din_in ? ST_RD : ST_WR;
            end else begin
              cnt_d   = WAIT_INIT;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (!strobe) begin
            state_d = ST_ADDR;
          end else if (cnt_q == 4'd1) begin
            state_d = is_rd_q ? ST_RD : ST_WR;
          end
        end
        ST_RD: begin
          if (!pin_din_in) begin
            state_d = ST_ADDR;
          end else begin
            ad_out_d = mem_rdata;
            ad_ena_d = 1'b1;
            rply_d   = 1'b1;
            state_d  = ST_HOLD;
          end
        end
        ST_WR: begin
          if (!pin_dout_in) begin
            state_d = ST_ADDR;
          end else begin
            mem_we  = 1'b1;
            rply_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!strobe) begin
            ad_out_d = '0;
            ad_ena_d = 1'b0;
            rply_d   = 1'b0;
            state_d  = ST_ADDR;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pin_clk or posedge pin_init) begin
    if (pin_init) begin
      state_q  <= ST_IDLE;
      sync_q   <= 1'b0;
      adr_q    <= '0;
      cnt_q    <= '0;
      is_rd_q  <= 1'b0;
      ad_out_q <= '0;
      ad_ena_q <= 1'b0;
      rply_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      is_rd_q  <= is_rd_d;
      ad_out_q <= ad_out_d;
      ad_ena_q <= ad_ena_d;
      rply_q   <= rply_d;
      sel_q    <= sel_d;
    end
  end

  // RAM contents survive reset; mem_we is only raised from ST_WR
  always_ff @(posedge pin_clk) begin
    if (mem_we) begin
      mem[adr_q[AW:1]] <= wr_word;
    end
  end

  assign pin_ad_out   = ad_out_q;
  assign pin_ad_ena   = ad_ena_q;
  assign pin_rply_out = rply_q;
  assign pin_sel      = sel_q;

endmodule

// File: tb/tb_vm1_qbus_slave.sv
// Bench for vm1_qbus_slave: two targets (WAIT=0 and WAIT=3) share one bus and
// are checked against a byte-addressed window model and fixed latency rules.
module tb_vm1_qbus_slave;

  localparam logic [15:0] BASE = 16'o100000;
  localparam int LAT0 = 2;
  localparam int LAT3 = 5;

  logic        clk = 1'b0;
  logic        init;
  logic [15:0] ad_in;
  logic        sync, din, dout, wtbt;
  logic [15:0] ad_out0, ad_out3;
  logic        ena0, ena3, rply0, rply3, sel0, sel3;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ref_mem [64];

  always #5 clk = ~clk;

  vm1_qbus_slave #(.BASE_ADDR(16'o100000), .AW(6), .WAIT(0)) dut0 (
    .pin_clk(clk), .pin_init(init), .pin_ad_in(ad_in), .pin_ad_out(ad_out0),
    .pin_ad_ena(ena0), .pin_sync_in(sync), .pin_din_in(din), .pin_dout_in(dout),
    .pin_wtbt_in(wtbt), .pin_rply_out(rply0), .pin_sel(sel0));

  vm1_qbus_slave #(.BASE_ADDR(16'o100000), .AW(6), .WAIT(3)) dut3 (
    .pin_clk(clk), .pin_init(init), .pin_ad_in(ad_in), .pin_ad_out(ad_out3),
    .pin_ad_ena(ena3), .pin_sync_in(sync), .pin_din_in(din), .pin_dout_in(dout),
    .pin_wtbt_in(wtbt), .pin_rply_out(rply3), .pin_sel(sel3));

  function automatic bit in_window(input logic [15:0] a);
    return (a >= BASE) && (a < BASE + 16'd128);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    return ref_mem[(a - BASE) / 2];
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input bit byte_wr);
    int idx;
    idx = (a - BASE) / 2;
    if (!byte_wr)         ref_mem[idx] = d;
    else if (a % 2 == 1)  ref_mem[idx] = (ref_mem[idx] & 16'h00FF) | (d & 16'hFF00);
    else                  ref_mem[idx] = (ref_mem[idx] & 16'hFF00) | (d & 16'h00FF);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_start(input logic [15:0] a);
    sync = 1'b0; din = 1'b0; dout = 1'b0;
    tick();
    ad_in = a;
    sync  = 1'b1;
    tick();
    check("sel0_after_sync", sel0, in_window(a));
    check("sel3_after_sync", sel3, in_window(a));
  endtask

  task automatic sync_end();
    sync = 1'b0; din = 1'b0; dout = 1'b0;
    tick();
    check("sel0_after_sync_drop", sel0, 1'b0);
    check("sel3_after_sync_drop", sel3, 1'b0);
  endtask

  // One data phase under the current SYNC; returns latencies counted in edges
  // from the first edge that samples the strobe, and data seen at reply.
  task automatic data_phase(input bit rd, input logic [15:0] wdata, input bit byte_wr,
                            output logic [15:0] rd0, output logic [15:0] rd3);
    int  lat0, lat3;
    bit  ena_bad;
    lat0 = 0; lat3 = 0; ena_bad = 1'b0; rd0 = '0; rd3 = '0;
    ad_in = rd ? 16'($urandom) : wdata;
    wtbt  = byte_wr;
    din   = rd;
    dout  = !rd;
    for (int k = 1; k <= 12 && (lat0 == 0 || lat3 == 0); k++) begin
      tick();
      if (ena0 && !(rd && rply0)) ena_bad = 1'b1;
      if (ena3 && !(rd && rply3)) ena_bad = 1'b1;
      if (rply0 && lat0 == 0) begin lat0 = k; rd0 = ad_out0; end
      if (rply3 && lat3 == 0) begin lat3 = k; rd3 = ad_out3; end
    end
    check("latency_wait0", lat0, LAT0);
    check("latency_wait3", lat3, LAT3);
    check("ad_ena_only_on_read_reply", ena_bad, 1'b0);
    din = 1'b0; dout = 1'b0;
    tick();
    check("rply_fall_wait0", rply0, 1'b0);
    check("rply_fall_wait3", rply3, 1'b0);
    check("ad_ena_fall", ena0 | ena3, 1'b0);
  endtask

  // Strobes asserted but no reply is allowed (miss or DIN&DOUT together).
  task automatic silent_phase(input bit both);
    bit any_rply, any_ena, any_sel;
    any_rply = 1'b0; any_ena = 1'b0; any_sel = 1'b0;
    din = 1'b1; dout = both; wtbt = 1'b0;
    ad_in = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      tick();
      any_rply |= rply0 | rply3;
      any_ena  |= ena0 | ena3;
      any_sel  |= sel0 | sel3;
    end
    check("no_rply_silent", any_rply, 1'b0);
    check("no_ad_ena_silent", any_ena, 1'b0);
    check("no_sel_silent", any_sel, 1'b0);
    din = 1'b0; dout = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input bit byte_wr);
    logic [15:0] r0, r3;
    sync_start(a);
    data_phase(1'b0, d, byte_wr, r0, r3);
    model_write(a, d, byte_wr);
    sync_end();
  endtask

  task automatic bus_read(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] r0, r3;
    sync_start(a);
    data_phase(1'b1, '0, 1'b0, r0, r3);
    check({name, "_wait0"}, r0, exp);
    check({name, "_wait3"}, r3, exp);
    sync_end();
  endtask

  typedef enum int { OP_W, OP_B, OP_R, OP_M } op_t;
  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [15:0] r0, r3, a, d;
    bit          any;
    init = 1'b0; ad_in = '0; sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0;

    vecs[0]  = '{OP_W, 16'o100004, 16'o123456, 16'o0};
    vecs[1]  = '{OP_R, 16'o100004, 16'o0,      16'o123456};
    vecs[2]  = '{OP_W, 16'o100004, 16'o000000, 16'o0};
    vecs[3]  = '{OP_B, 16'o100005, 16'o125377, 16'o0};
    vecs[4]  = '{OP_R, 16'o100004, 16'o0,      16'o125000};
    vecs[5]  = '{OP_B, 16'o100004, 16'o177125, 16'o0};
    vecs[6]  = '{OP_R, 16'o100005, 16'o0,      16'o125125};
    vecs[7]  = '{OP_W, 16'o100176, 16'o054321, 16'o0};
    vecs[8]  = '{OP_R, 16'o100177, 16'o0,      16'o054321};
    vecs[9]  = '{OP_M, 16'o177560, 16'o0,      16'o0};
    vecs[10] = '{OP_M, 16'o100200, 16'o0,      16'o0};
    vecs[11] = '{OP_M, 16'o077776, 16'o0,      16'o0};
    vecs[12] = '{OP_W, 16'o100000, 16'o000001, 16'o0};
    vecs[13] = '{OP_R, 16'o100000, 16'o0,      16'o000001};

    #1 init = 1'b1;
    #1;
    check("reset_ad_out", {ad_out0, ad_out3}, 32'd0);
    check("reset_ena_rply_sel", {ena0, rply0, sel0, ena3, rply3, sel3}, 6'd0);
    repeat (3) @(posedge clk);
    #1 init = 1'b0;

    for (int i = 0; i < 64; i++) bus_write(BASE + 16'(2 * i), 16'($urandom), 1'b0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_W, OP_B: bus_write(vecs[i].addr, vecs[i].data, vecs[i].op == OP_B);
        OP_R:       bus_read($sformatf("vec%0d_read", i), vecs[i].addr, vecs[i].exp);
        default: begin
          sync_start(vecs[i].addr);
          silent_phase(1'b0);
          sync_end();
        end
      endcase
    end

    // DATIO under one SYNC, then DIN&DOUT together must stay silent and not write
    bus_write(16'o100010, 16'o7, 1'b0);
    sync_start(16'o100010);
    data_phase(1'b1, '0, 1'b0, r0, r3);
    check("datio_first_read", r0, 16'o7);
    data_phase(1'b0, 16'o10, 1'b0, r0, r3);
    model_write(16'o100010, 16'o10, 1'b0);
    data_phase(1'b1, '0, 1'b0, r0, r3);
    check("datio_second_read_w0", r0, 16'o10);
    check("datio_second_read_w3", r3, 16'o10);
    sync_end();
    sync_start(16'o100010);
    ad_in = 16'o177777;
    silent_phase(1'b1);
    sync_end();
    bus_read("after_proto_error", 16'o100010, 16'o10);

    // SYNC dropped while the WAIT=3 target is still counting
    sync_start(16'o100004);
    din = 1'b1;
    any = 1'b0;
    repeat (2) begin tick(); any |= rply3; end
    sync = 1'b0; din = 1'b0;
    tick();
    any |= rply3;
    check("abort_no_rply_wait3", any, 1'b0);
    check("abort_rply_wait0_dropped", rply0, 1'b0);
    bus_read("after_abort", 16'o100004, model_read(16'o100004));

    // async reset in the middle of a write: outputs drop at once, RAM untouched
    sync_start(16'o100004);
    ad_in = 16'o011111; dout = 1'b1; wtbt = 1'b0;
    @(posedge clk);
    #3 init = 1'b1;
    #1;
    check("midreset_outputs", {rply0, ena0, sel0, rply3, ena3, sel3}, 6'd0);
    check("midreset_ad_out", {ad_out0, ad_out3}, 32'd0);
    @(posedge clk);
    #1 init = 1'b0; sync = 1'b0; dout = 1'b0;
    tick();
    bus_read("after_midreset", 16'o100004, model_read(16'o100004));

    // async reset while a read reply is being held
    sync_start(16'o100176);
    din = 1'b1;
    tick(); tick();
    check("pre_reset_rply", rply0, 1'b1);
    #3 init = 1'b1;
    #1;
    check("reset_during_hold", {rply0, ena0, sel0, ad_out0}, 19'd0);
    @(posedge clk);
    #1 init = 1'b0; sync = 1'b0; din = 1'b0;
    tick();

    for (int t = 0; t < 60; t++) begin
      int op;
      op = $urandom_range(0, 3);
      a  = BASE + 16'($urandom_range(0, 127));
      d  = 16'($urandom);
      if (op == 3) begin
        a = 16'($urandom);
        if (in_window(a)) a = a ^ 16'h0100;
        sync_start(a);
        silent_phase(1'b0);
        sync_end();
      end else begin
        sync_start(a);
        for (int p = 0; p < (($urandom_range(0, 3) == 0) ? 2 : 1); p++) begin
          if (op == 2 || p == 1) begin
            data_phase(1'b1, '0, 1'b0, r0, r3);
            check("rand_read_wait0", r0, model_read(a));
            check("rand_read_wait3", r3, model_read(a));
          end else begin
            data_phase(1'b0, d, op == 1, r0, r3);
            model_write(a, d, op == 1);
          end
        end
        sync_end();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
